regfile_wb_arbiter: RTL and testbench



---
 rtl/regfile_wb_arbiter.sv | 134 +++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: shares the single register-file write port between the
// in-order pipeline write-back (A, priority) and queued long-latency results
// (B). A wait counter stalls A once the B head has waited MAX_WAIT cycles.
// Optional macro WB_ARB_BYPASS_EN: with an empty FIFO and no A request, a B
// result is granted straight through without being enqueued.
//
// Handshakes: B transfers when b_valid & b_ready on a rising edge; the
// producer holds b_valid/b_rd/b_data stable until that happens. A is consumed
// every cycle a_valid=1 and a_stall=0; while a_stall=1 A holds its inputs.
module regfile_wb_arbiter #(
  parameter int DEPTH    = 4,
  parameter int MAX_WAIT = 3,
  parameter int CW       = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        a_valid,
  input  logic [4:0]  a_rd,
  input  logic [31:0] a_data,
  output logic        a_stall,
  input  logic        b_valid,
  output logic        b_ready,
  input  logic [4:0]  b_rd,
  input  logic [31:0] b_data,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic        b_pending
);

  localparam int AW   = $clog2(DEPTH);
  localparam int CNTW = AW + 1;

  logic [4:0]      rd_mem   [DEPTH];
  logic [31:0]     data_mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CNTW-1:0] count;
  logic [CW-1:0]   wait_cnt;

  logic        fifo_empty;
  logic        fifo_full;
  logic        bypass;
  logic        head_valid;
  logic [4:0]  head_rd;
  logic [31:0] head_data;
  logic        grant_a;
  logic        grant_b;
  logic        push;
  logic        pop;

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == CNTW'(DEPTH));

`ifdef WB_ARB_BYPASS_EN
  // Empty FIFO and idle pipeline: take B straight to the write port.
  assign bypass = fifo_empty & b_valid & ~a_valid;
`else
  assign bypass = 1'b0;
`endif

  assign head_valid = ~fifo_empty | bypass;
  assign head_rd    = bypass ? b_rd   : rd_mem[rd_ptr];
  assign head_data  = bypass ? b_data : data_mem[rd_ptr];

  // A wins unless the B head has waited long enough (or A is idle).
  assign grant_b = head_valid & (~a_valid | (wait_cnt >= CW'(MAX_WAIT)));
  assign grant_a = a_valid & ~grant_b;
  assign a_stall = a_valid & grant_b;

  // Full blocks a push even if a pop frees a slot this cycle; b_ready is
  // forced low while reset is asserted.
  assign b_ready   = rst_n & ~fifo_full;
  assign b_pending = ~fifo_empty;

  assign push = b_valid & b_ready & ~bypass;
  assign pop  = grant_b & ~bypass;

  // FIFO storage: payload only, no reset needed.
  always_ff @(posedge clk) begin
    if (push) begin
      rd_mem[wr_ptr]   <= b_rd;
      data_mem[wr_ptr] <= b_data;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Starvation counter: cleared on pop or empty, saturates at MAX_WAIT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
    end else if (pop || fifo_empty) begin
      wait_cnt <= '0;
    end else if (wait_cnt < CW'(MAX_WAIT)) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  // Registered write port; x0 writes consume the grant but never assert we.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else if (grant_b) begin
      rf_we    <= (head_rd != 5'd0);
      rf_waddr <= head_rd;
      rf_wdata <= head_data;
    end else if (grant_a) begin
      rf_we    <= (a_rd != 5'd0);
      rf_waddr <= a_rd;
      rf_wdata <= a_data;
    end else begin
      rf_we <= 1'b0;
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: directed scenarios plus randomized traffic, checked
// against a queue-based reference of the arbitration rules.
module tb_regfile_wb_arbiter;

  localparam int DEPTH    = 4;
  localparam int MAX_WAIT = 3;

  logic        clk;
  logic        rst_n;
  logic        a_valid;
  logic [4:0]  a_rd;
  logic [31:0] a_data;
  logic        a_stall;
  logic        b_valid;
  logic        b_ready;
  logic [4:0]  b_rd;
  logic [31:0] b_data;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        b_pending;

  regfile_wb_arbiter #(.DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT), .CW(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_rd(a_rd), .a_data(a_data), .a_stall(a_stall),
    .b_valid(b_valid), .b_ready(b_ready), .b_rd(b_rd), .b_data(b_data),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .b_pending(b_pending)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  logic [36:0] exp_q[$];        // {rd, data} queued B results
  int          wait_m;
  logic        exp_we;
  logic [4:0]  exp_waddr;
  logic [31:0] exp_wdata;
  logic        last_stall;      // model says A was stalled in the last step
  logic        last_b_taken;    // model says B transferred in the last step
  logic        obs_stall;       // DUT a_stall seen in the last step

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    wait_m       = 0;
    exp_we       = 1'b0;
    exp_waddr    = '0;
    exp_wdata    = '0;
    last_stall   = 1'b0;
    last_b_taken = 1'b0;
  endtask

  task automatic drive_idle();
    a_valid = 1'b0; a_rd = '0; a_data = '0;
    b_valid = 1'b0; b_rd = '0; b_data = '0;
  endtask

  // One clock cycle: drive (just after posedge), check at negedge, advance model.
  task automatic step(input logic av, input logic [4:0] ar, input logic [31:0] ad,
                      input logic bv, input logic [4:0] br, input logic [31:0] bd);
    bit byp, hv, gb, ga, rdy;
    int size_before;
    logic [36:0] e;
    logic [4:0]  g_rd;
    logic [31:0] g_dat;
    a_valid = av; a_rd = ar; a_data = ad;
    b_valid = bv; b_rd = br; b_data = bd;
    @(negedge clk);
    byp = 1'b0;
`ifdef WB_ARB_BYPASS_EN
    byp = (exp_q.size() == 0) && bv && !av;
`endif
    hv  = (exp_q.size() != 0) || byp;
    gb  = hv && (!av || wait_m >= MAX_WAIT);
    ga  = av && !gb;
    rdy = (exp_q.size() != DEPTH);
    check("a_stall",   a_stall,   av && gb);
    check("b_ready",   b_ready,   rdy);
    check("b_pending", b_pending, exp_q.size() != 0);
    check("rf_we",     rf_we,     exp_we);
    check("rf_waddr",  rf_waddr,  exp_waddr);
    check("rf_wdata",  rf_wdata,  exp_wdata);
    obs_stall    = a_stall;
    last_stall   = av && gb;
    last_b_taken = bv && rdy;
    size_before  = exp_q.size();
    g_rd = '0; g_dat = '0;
    if (gb) begin
      if (byp) begin
        g_rd = br; g_dat = bd;
      end else begin
        e = exp_q.pop_front();
        g_rd = e[36:32]; g_dat = e[31:0];
      end
    end else if (ga) begin
      g_rd = ar; g_dat = ad;
    end
    if (gb || ga) begin
      exp_we = (g_rd != 0); exp_waddr = g_rd; exp_wdata = g_dat;
    end else begin
      exp_we = 1'b0;
    end
    if (bv && rdy && !byp) exp_q.push_back({br, bd});
    if ((gb && !byp) || size_before == 0) wait_m = 0;
    else if (wait_m < MAX_WAIT) wait_m++;
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) step(0, 0, 0, 0, 0, 0);
    check("drain_done", exp_q.size(), 0);
    step(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    logic        av, bv;
    logic [4:0]  ar, br;
    logic [31:0] ad, bd;

    // Reset block
    rst_n = 1'b0;
    drive_idle();
    model_reset();
    #1;
    check("rst_rf_we",     rf_we,     0);
    check("rst_rf_waddr",  rf_waddr,  0);
    check("rst_rf_wdata",  rf_wdata,  0);
    check("rst_b_pending", b_pending, 0);
    check("rst_b_ready",   b_ready,   0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Pipeline write to rd 5
    step(1, 5, 32'hDEADBEEF, 0, 0, 0);
    check("t2_we",    rf_we,    1);
    check("t2_waddr", rf_waddr, 5);
    check("t2_wdata", rf_wdata, 32'hDEADBEEF);
    check("t2_stall", obs_stall, 0);

    // Starvation: A continuous, one B entry
    step(1, 1, 32'h11, 1, 7, 32'h1234);
    step(1, 2, 32'h22, 0, 0, 0);
    check("t3_a1", obs_stall, 0);
    step(1, 3, 32'h33, 0, 0, 0);
    check("t3_a2", obs_stall, 0);
    step(1, 4, 32'h44, 0, 0, 0);
    check("t3_a3", obs_stall, 0);
    step(1, 6, 32'h66, 0, 0, 0);
    check("t3_stall", obs_stall, 1);
    check("t3_waddr", rf_waddr, 7);
    check("t3_wdata", rf_wdata, 32'h1234);
    step(1, 6, 32'h66, 0, 0, 0);   // held A retires now
    check("t3_a_after", rf_waddr, 6);
    drain();

    // Fill to DEPTH behind A, 5th offer refused, drain in order
    for (int i = 0; i < 4; i++) step(1, 5'(10 + i), 32'h100 + i, 1, 5'(20 + i), 32'hB00 + i);
    check("t4_full_ready", b_ready, 0);
    step(0, 0, 0, 1, 24, 32'hB04);
    check("t4_first_out", rf_waddr, 20);
    drain();

    // Writes to x0
    step(1, 0, 32'hFFFFFFFF, 0, 0, 0);
    check("t5_a_we", rf_we, 0);
    check("t5_stall", obs_stall, 0);
    step(0, 0, 0, 1, 0, 32'hAAAA);
    step(0, 0, 0, 0, 0, 0);
    check("t5_b_we", rf_we, 0);
    check("t5_b_wdata", rf_wdata, 32'hAAAA);
    check("t5_empty", b_pending, 0);

    // B latency from empty, idle pipeline
    step(0, 0, 0, 1, 9, 32'h99);
`ifdef WB_ARB_BYPASS_EN
    check("t6_we_1",   rf_we,     1);
    check("t6_pend_1", b_pending, 0);
`else
    check("t6_we_1",   rf_we,     0);
    check("t6_pend_1", b_pending, 1);
`endif
    step(0, 0, 0, 0, 0, 0);
`ifdef WB_ARB_BYPASS_EN
    check("t6_we_2", rf_we, 0);
`else
    check("t6_we_2",    rf_we,    1);
    check("t6_waddr_2", rf_waddr, 9);
`endif
    check("t6_pend_2", b_pending, 0);

    // Reset mid-stream with 3 entries queued
    for (int i = 0; i < 3; i++) step(1, 5'(1 + i), 32'h50 + i, 1, 5'(12 + i), 32'hC0 + i);
    check("t1_pending", b_pending, 1);
    drive_idle();
    #2 rst_n = 1'b0;
    #1;
    check("t1_rst_we",      rf_we,     0);
    check("t1_rst_pending", b_pending, 0);
    check("t1_rst_ready",   b_ready,   0);
    model_reset();
    @(negedge clk) rst_n = 1'b1;
    #1;
    check("t1_rel_ready",   b_ready,   1);
    check("t1_rel_pending", b_pending, 0);
    @(posedge clk);
    #1;

    // Randomized traffic
    av = 0; ar = 0; ad = 0; bv = 0; br = 0; bd = 0;
    for (int n = 0; n < 600; n++) begin
      if (!(av && last_stall)) begin
        av = ($urandom_range(0, 99) < ((n / 100) % 2 ? 80 : 40));
        ar = 5'($urandom_range(0, 31));
        ad = $urandom;
      end
      if (!(bv && !last_b_taken)) begin
        bv = ($urandom_range(0, 99) < ((n / 150) % 2 ? 60 : 30));
        br = 5'($urandom_range(0, 31));
        bd = $urandom;
      end
      step(av, ar, ad, bv, br, bd);
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
